// File: rtl/cam_dvp_tx.sv
// cam_dvp_tx: DVP camera-bus transmitter that generates test-pattern frames.
// pclk runs at clk/2. Every frame-level output changes only on the clk edge
// where pclk falls (a "tick"), so a receiver sampling on the rising edge of
// pclk always sees stable values. Each pixel is RGB565, sent high byte first.
module cam_dvp_tx #(
    parameter int CAM_SCREEN_X = 160,
    parameter int CAM_SCREEN_Y = 120,
    parameter int HBLANK       = 144,
    parameter int VS_LINES     = 3,
    parameter int VBP_LINES    = 17,
    parameter int VFP_LINES    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    output logic        pclk,
    output logic        href,
    output logic        vsync,
    output logic [7:0]  data,
    output logic        frame_done
);

    localparam int ACT_LEN   = 2 * CAM_SCREEN_X;
    localparam int LINE_LEN  = ACT_LEN + HBLANK;
    localparam int MAX_VB    = (VS_LINES > VBP_LINES) ? VS_LINES : VBP_LINES;
    localparam int MAX_FY    = (VFP_LINES > CAM_SCREEN_Y) ? VFP_LINES : CAM_SCREEN_Y;
    localparam int MAX_LINES = (MAX_VB > MAX_FY) ? MAX_VB : MAX_FY;
    localparam int HW        = $clog2(LINE_LEN + 1);
    localparam int LW        = $clog2(MAX_LINES + 1);

    localparam logic [HW-1:0] H_LAST     = HW'(LINE_LEN - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(ACT_LEN);
    localparam logic [LW-1:0] L_VS_LAST  = LW'(VS_LINES - 1);
    localparam logic [LW-1:0] L_VBP_LAST = LW'(VBP_LINES - 1);
    localparam logic [LW-1:0] L_ACT_LAST = LW'(CAM_SCREEN_Y - 1);
    localparam logic [LW-1:0] L_VFP_LAST = LW'(VFP_LINES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBP    = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFP    = 3'd4
    } state_t;

    // RGB565 colour of pixel (x, y) for the selected test pattern.
    function automatic logic [15:0] pixel_color(
        input logic [1:0]    pat,
        input logic [15:0]   solid,
        input logic [HW-1:0] x,
        input logic [LW-1:0] y
    );
        logic [7:0]  x8;
        logic [7:0]  y8;
        logic [2:0]  bar;
        logic [15:0] c;
        x8  = 8'(x);
        y8  = 8'(y);
        // bar = floor(x*8 / CAM_SCREEN_X) without a divider: count thresholds passed
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if ((32'(x) * 32'd8) >= (32'(k) * 32'(CAM_SCREEN_X))) begin
                bar = bar + 3'd1;
            end else begin
                bar = bar;
            end
        end
        case (pat)
            2'd0: begin
                case (bar)
                    3'd0:    c = 16'hFFFF;
                    3'd1:    c = 16'hFFE0;
                    3'd2:    c = 16'h07FF;
                    3'd3:    c = 16'h07E0;
                    3'd4:    c = 16'hF81F;
                    3'd5:    c = 16'hF800;
                    3'd6:    c = 16'h001F;
                    default: c = 16'h0000;
                endcase
            end
            2'd1:    c = {y8, x8};
            2'd2:    c = solid;
            2'd3:    c = (x8[3] ^ y8[3]) ? 16'hFFFF : 16'h0000;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic [HW-1:0] r_hcnt;
    logic [HW-1:0] w_hcnt_nxt;
    logic [LW-1:0] r_lcnt;
    logic [LW-1:0] w_lcnt_nxt;
    logic [1:0]    r_pat;
    logic [1:0]    w_pat_nxt;
    logic [15:0]   r_solid;
    logic [15:0]   w_solid_nxt;
    logic          w_done_nxt;
    logic          w_start;
    logic          w_line_end;
    logic          w_phase_end;
    logic          w_tick;

    logic          r_pclk;
    logic          r_href;
    logic          r_vsync;
    logic [7:0]    r_data;
    logic          r_frame_done;
    logic          w_href_nxt;
    logic          w_vsync_nxt;
    logic [7:0]    w_data_nxt;
    logic [HW-1:0] w_x;
    logic [15:0]   w_color;

    // A tick is the edge on which pclk goes from 1 to 0.
    assign w_tick = r_pclk;

    // Last line of the current phase, per state.
    always_comb begin
        w_phase_end = 1'b0;
        case (r_state)
            ST_VSYNC:  w_phase_end = (r_lcnt == L_VS_LAST);
            ST_VBP:    w_phase_end = (r_lcnt == L_VBP_LAST);
            ST_ACTIVE: w_phase_end = (r_lcnt == L_ACT_LAST);
            ST_VFP:    w_phase_end = (r_lcnt == L_VFP_LAST);
            default:   w_phase_end = 1'b0;
        endcase
    end

    // Next frame position (state, pclk-in-line, line-in-phase) and frame start.
    always_comb begin
        w_state_nxt = r_state;
        w_hcnt_nxt  = r_hcnt;
        w_lcnt_nxt  = r_lcnt;
        w_pat_nxt   = r_pat;
        w_solid_nxt = r_solid;
        w_done_nxt  = 1'b0;
        w_start     = 1'b0;
        w_line_end  = (r_hcnt == H_LAST);
        case (r_state)
            ST_IDLE: begin
                w_start = enable;
            end
            ST_VSYNC, ST_VBP, ST_ACTIVE, ST_VFP: begin
                w_hcnt_nxt = w_line_end ? '0 : (r_hcnt + 1'b1);
                if (w_line_end && w_phase_end) begin
                    w_lcnt_nxt = '0;
                    case (r_state)
                        ST_VSYNC:  w_state_nxt = ST_VBP;
                        ST_VBP:    w_state_nxt = ST_ACTIVE;
                        ST_ACTIVE: w_state_nxt = ST_VFP;
                        default: begin
                            // end of VFP: frame complete, restart at once if still enabled
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_IDLE;
                            w_start     = enable;
                        end
                    endcase
                end else if (w_line_end) begin
                    w_lcnt_nxt = r_lcnt + 1'b1;
                end else begin
                    w_lcnt_nxt = r_lcnt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_hcnt_nxt  = '0;
                w_lcnt_nxt  = '0;
            end
        endcase
        // pattern and colour are captured only at frame start
        if (w_start) begin
            w_state_nxt = ST_VSYNC;
            w_hcnt_nxt  = '0;
            w_lcnt_nxt  = '0;
            w_pat_nxt   = pattern_sel;
            w_solid_nxt = solid_color;
        end else begin
            w_pat_nxt   = r_pat;
            w_solid_nxt = r_solid;
        end
    end

    // Bus values for the pclk period that begins at the coming tick.
    always_comb begin
        w_href_nxt  = (w_state_nxt == ST_ACTIVE) && (w_hcnt_nxt < H_ACT);
        w_vsync_nxt = (w_state_nxt == ST_VSYNC);
        w_x         = {1'b0, w_hcnt_nxt[HW-1:1]};
        w_color     = pixel_color(w_pat_nxt, w_solid_nxt, w_x, w_lcnt_nxt);
        if (w_href_nxt) begin
            w_data_nxt = w_hcnt_nxt[0] ? w_color[7:0] : w_color[15:8];
        end else begin
            w_data_nxt = 8'h00;
        end
    end

    // Pixel clock divider: toggles every clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pclk <= 1'b0;
        end else begin
            r_pclk <= ~r_pclk;
        end
    end

    // FSM state and frame counters advance once per pclk period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_hcnt  <= '0;
            r_lcnt  <= '0;
        end else if (w_tick) begin
            r_state <= w_state_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_lcnt  <= w_lcnt_nxt;
        end else begin
            r_state <= r_state;
            r_hcnt  <= r_hcnt;
            r_lcnt  <= r_lcnt;
        end
    end

    // Per-frame pattern selection and solid colour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pat   <= 2'd0;
            r_solid <= 16'h0000;
        end else if (w_tick) begin
            r_pat   <= w_pat_nxt;
            r_solid <= w_solid_nxt;
        end else begin
            r_pat   <= r_pat;
            r_solid <= r_solid;
        end
    end

    // Registered bus outputs; frame_done lasts exactly one clk after its tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_href       <= 1'b0;
            r_vsync      <= 1'b0;
            r_data       <= 8'h00;
            r_frame_done <= 1'b0;
        end else if (w_tick) begin
            r_href       <= w_href_nxt;
            r_vsync      <= w_vsync_nxt;
            r_data       <= w_data_nxt;
            r_frame_done <= w_done_nxt;
        end else begin
            r_href       <= r_href;
            r_vsync      <= r_vsync;
            r_data       <= r_data;
            r_frame_done <= 1'b0;
        end
    end

    assign pclk       = r_pclk;
    assign href       = r_href;
    assign vsync      = r_vsync;
    assign data       = r_data;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_cam_dvp_tx.sv
// Self-checking bench for cam_dvp_tx with a reduced frame geometry.
// The reference model tracks only "frame active" and the pclk-period index
// inside the frame, and derives every bus value arithmetically from it.
module tb_cam_dvp_tx;

    localparam int X      = 16;
    localparam int Y      = 12;
    localparam int HB     = 6;
    localparam int VS     = 2;
    localparam int VBP    = 3;
    localparam int VFP    = 2;
    localparam int LINE   = 2 * X + HB;
    localparam int FRAME_LEN = (VS + VBP + Y + VFP) * LINE;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [15:0] solid_color;
    logic        pclk;
    logic        href;
    logic        vsync;
    logic [7:0]  data;
    logic        frame_done;

    int n_checks;
    int n_errors;
    int n_done_exp;
    int n_done_seen;

    // reference model state
    int          m_edge;
    bit          m_act;
    int          m_p;
    logic [1:0]  m_pat;
    logic [15:0] m_solid;
    bit          m_done;

    cam_dvp_tx #(
        .CAM_SCREEN_X (X),
        .CAM_SCREEN_Y (Y),
        .HBLANK       (HB),
        .VS_LINES     (VS),
        .VBP_LINES    (VBP),
        .VFP_LINES    (VFP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .solid_color (solid_color),
        .pclk        (pclk),
        .href        (href),
        .vsync       (vsync),
        .data        (data),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] bar_color(input int bar);
        case (bar)
            0:       return 16'hFFFF;
            1:       return 16'hFFE0;
            2:       return 16'h07FF;
            3:       return 16'h07E0;
            4:       return 16'hF81F;
            5:       return 16'hF800;
            6:       return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    // Expected bus for pclk period p of the frame.
    function automatic void ref_out(input bit act, input int p, input logic [1:0] pat,
                                    input logic [15:0] sc, output bit vs, output bit hr,
                                    output logic [7:0] d);
        int line;
        int col;
        int x;
        int y;
        logic [15:0] c;
        logic [15:0] xv;
        logic [15:0] yv;
        vs = 1'b0;
        hr = 1'b0;
        d  = 8'h00;
        if (act) begin
            line = p / LINE;
            col  = p % LINE;
            vs   = (line < VS);
            if (line >= VS + VBP && line < VS + VBP + Y && col < 2 * X) begin
                hr = 1'b1;
                x  = col / 2;
                y  = line - VS - VBP;
                xv = 16'(x);
                yv = 16'(y);
                case (pat)
                    2'd0:    c = bar_color((x * 8) / X);
                    2'd1:    c = {yv[7:0], xv[7:0]};
                    2'd2:    c = sc;
                    default: c = (((x / 8) % 2) != ((y / 8) % 2)) ? 16'hFFFF : 16'h0000;
                endcase
                d = (col % 2 == 0) ? c[15:8] : c[7:0];
            end
        end
    endfunction

    // Reference model: advance one pclk period on every second clk edge after reset.
    initial begin
        m_edge = 0; m_act = 1'b0; m_p = 0; m_pat = 2'd0; m_solid = 16'h0; m_done = 1'b0;
        n_done_exp = 0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_edge = 0; m_act = 1'b0; m_p = 0; m_pat = 2'd0; m_solid = 16'h0; m_done = 1'b0;
            end else begin
                m_edge = m_edge + 1;
                m_done = 1'b0;
                if (m_edge % 2 == 0) begin
                    if (m_act) begin
                        m_p = m_p + 1;
                        if (m_p == FRAME_LEN) begin
                            m_done     = 1'b1;
                            n_done_exp = n_done_exp + 1;
                            m_act      = 1'b0;
                        end
                    end
                    if (!m_act && enable) begin
                        m_act   = 1'b1;
                        m_p     = 0;
                        m_pat   = pattern_sel;
                        m_solid = solid_color;
                    end
                end
            end
        end
    end

    // Monitor: compare every output against the model mid-cycle.
    initial begin
        bit         e_vs;
        bit         e_hr;
        logic [7:0] e_d;
        n_done_seen = 0;
        forever begin
            @(negedge clk);
            ref_out(m_act, m_p, m_pat, m_solid, e_vs, e_hr, e_d);
            check_eq("pclk", 16'(pclk), 16'(m_edge % 2));
            check_eq("vsync", 16'(vsync), 16'(e_vs));
            check_eq("href", 16'(href), 16'(e_hr));
            check_eq("data", 16'(data), 16'(e_d));
            check_eq("frame_done", 16'(frame_done), 16'(m_done));
            if (frame_done) n_done_seen = n_done_seen + 1;
        end
    end

    // Stimulus
    initial begin
        int drop;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; enable = 1'b0; pattern_sel = 2'd0; solid_color = 16'h0000;
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);

        // one frame per pattern, inputs scrambled mid-frame, enable dropped mid-frame
        for (int pat = 0; pat < 4; pat++) begin
            pattern_sel = 2'(pat);
            solid_color = 16'($urandom);
            enable      = 1'b1;
            repeat (4) @(negedge clk);
            pattern_sel = 2'($urandom);
            solid_color = 16'($urandom);
            drop = $urandom_range(400, 1250);
            repeat (drop - 4) @(negedge clk);
            enable      = 1'b0;
            pattern_sel = 2'($urandom);
            solid_color = 16'($urandom);
            repeat (2 * FRAME_LEN - drop + 60) @(negedge clk);
        end

        // back-to-back frames with inputs changing all the time
        enable = 1'b1;
        for (int i = 0; i < 70; i++) begin
            repeat (50) @(negedge clk);
            pattern_sel = 2'($urandom);
            solid_color = 16'($urandom);
        end
        enable = 1'b0;
        repeat (2 * FRAME_LEN + 20) @(negedge clk);

        // asynchronous reset in the middle of an active line
        pattern_sel = 2'd1;
        enable      = 1'b1;
        repeat (2 * ((VS + VBP + 3) * LINE + 10)) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("rst_async_pclk", 16'(pclk), 16'h0000);
        check_eq("rst_async_href", 16'(href), 16'h0000);
        check_eq("rst_async_vsync", 16'(vsync), 16'h0000);
        check_eq("rst_async_data", 16'(data), 16'h0000);
        check_eq("rst_async_done", 16'(frame_done), 16'h0000);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        pattern_sel = 2'd2;
        solid_color = 16'hA5C3;
        repeat (2 * FRAME_LEN + 40) @(negedge clk);
        enable = 1'b0;
        repeat (2 * FRAME_LEN + 40) @(negedge clk);

        check_eq("frame_done_count", 16'(n_done_seen), 16'(n_done_exp));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cam_dvp_tx.md
CAM_DVP_TX -- requirements
Module: cam_dvp_tx

Interface
REQ-001 The block SHALL have parameter CAM_SCREEN_X, default 160, meaning active pixels per line.
REQ-002 The block SHALL have parameter CAM_SCREEN_Y, default 120, meaning active lines per frame.
REQ-003 The block SHALL have parameter HBLANK, default 144, meaning href-low pclk periods after each active line.
REQ-004 The block SHALL have parameters VS_LINES, default 3; VBP_LINES, default 17; VFP_LINES, default 10; each meaning a line count.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port enable, input, 1 bit: permits starting a new frame.
REQ-008 The block SHALL have port pattern_sel, input, 2 bits: test pattern select.
REQ-009 The block SHALL have port solid_color, input, 16 bits: RGB565 colour for pattern 2.
REQ-010 The block SHALL have port pclk, output, 1 bit: pixel clock, clk/2.
REQ-011 The block SHALL have ports href and vsync, outputs, 1 bit each: line valid and frame sync.
REQ-012 The block SHALL have port data, output, 8 bits: camera byte bus (D0-D7).
REQ-013 The block SHALL have port frame_done, output, 1 bit: one-clk pulse at frame end.

Function
REQ-014 pclk SHALL toggle every clk cycle; "tick" is the clk edge on which pclk goes 1->0.
REQ-015 href, vsync and data SHALL change only on ticks, so they are stable at pclk rising edges.
REQ-016 The FSM SHALL have states IDLE, VSYNC, VBP, ACTIVE and VFP, with counters in pclk periods and lines.
REQ-017 One line period SHALL be 2*CAM_SCREEN_X+HBLANK pclk periods (464 by default) in every non-IDLE state.
REQ-018 On a tick in IDLE with enable=1, the block SHALL go to VSYNC; in the same tick it SHALL latch pattern_sel and solid_color, which stay fixed for the frame.
REQ-019 vsync SHALL be 1 only in VSYNC, for exactly VS_LINES line periods; the block SHALL then go to VBP for VBP_LINES line periods.
REQ-020 In ACTIVE, for each of CAM_SCREEN_Y lines, href SHALL be 1 for 2*CAM_SCREEN_X pclk periods, then 0 for HBLANK.
REQ-021 While href=1, each pixel SHALL be 2 bytes: RGB565[15:8] first, then [7:0]; x counts 0..CAM_SCREEN_X-1 and y counts 0..CAM_SCREEN_Y-1.
REQ-022 While href=0, data SHALL be 8'h00.
REQ-023 After the last ACTIVE line, the block SHALL go to VFP for VFP_LINES line periods.
REQ-024 At the end of VFP, the block SHALL pulse frame_done for one clk, then go to VSYNC if enable=1, else IDLE; there is no idle gap between back-to-back frames.
REQ-025 If enable drops mid-frame, the current frame SHALL complete fully.
REQ-026 Pattern 0 SHALL be colour bars: bar = (x*8)/CAM_SCREEN_X in the order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
REQ-027 Pattern 1 SHALL be {y[7:0], x[7:0]} (coordinate pattern).
REQ-028 Pattern 2 SHALL be the latched solid_color.
REQ-029 Pattern 3 SHALL be (x[3]^y[3]) ? FFFF : 0000.
REQ-030 Changes to pattern_sel or solid_color mid-frame SHALL take effect only at the next frame start.
REQ-031 Counter widths SHALL cover the parameter maxima; x, y and line counters SHALL wrap to 0 on terminal count.

Reset
REQ-032 While rst=0, pclk, href, vsync, data and frame_done SHALL be 0, the FSM SHALL be IDLE and all counters 0, asynchronously, including mid-frame.
REQ-033 After rst rises, the first tick SHALL occur on the second clk edge, and a frame SHALL start only per REQ-018.

Verification
REQ-034 Reset, enable=1, defaults -> vsync high for 1392 pclk; first href rise at pclk (3+17)*464 = 9280 after vsync rise; 120 href pulses of 320 pclk each; frame_done once after 150 lines.
REQ-035 pattern_sel=1 -> at line y=5, pixel x=7, the bytes are 8'h05 then 8'h07; the last pixel of the frame is 8'h77, 8'h9F.
REQ-036 pattern_sel=0 -> x=0 gives FF,FF; x=20 gives FF,E0; x=159 gives 00,00; data is sampled on the pclk rising edge.
REQ-037 pattern_sel=2 with solid_color=16'hA5C3, changed to 16'h1234 mid-frame -> the whole frame is A5,C3 and the next frame is 12,34.
REQ-038 Drop enable during ACTIVE line 60 -> the frame completes, frame_done pulses, and all outputs then stay 0 in IDLE.
REQ-039 Assert rst=0 during ACTIVE -> all outputs are 0 immediately; after release with enable=1, a fresh frame starts with vsync.
